operand_fetch: RTL and testbench
================================

# operand_fetch

Decode-side reader of the GPR. Accepts decoded instructions on a valid/ready handshake and drives the GPR read addresses `A1`/`A2`. Merges `RD1`/`RD2` with same-cycle bypass from the Execute and Writeback write ports, and holds the result in a registered ID/EX operand slot. A 32-entry load scoreboard stalls instructions whose sources are still waiting on an outstanding load.

## Interface
Parameters:
- `XLEN`, 32, operand/data width
- `NREG`, 32, architectural register count; address width is `$clog2(NREG)` = 5

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage accepts this cycle (combinational)
- `in_rs1`, `in_rs2`  in  5  source register addresses
- `in_rd`  in  5  destination register
- `in_rd_we`  in  1  instruction writes `in_rd`
- `in_is_load`  in  1  instruction is a load (result arrives via Writeback only)
- `A1`, `A2`  out  5  GPR read addresses; equal to `in_rs1`/`in_rs2` (combinational)
- `RD1`, `RD2`  in  XLEN  GPR read data (pre-write value for same-cycle writes)
- `RegWE_E`, `A3`, `WD3`  in  1/5/XLEN  snooped Execute write port
- `RegWE_W`, `A4`, `WD4`  in  1/5/XLEN  snooped Writeback write port
- `flush`  in  1  kill the held slot
- `out_valid`  out  1  operand slot holds an instruction
- `out_ready`  in  1  Execute consumes the slot
- `out_op1`, `out_op2`  out  XLEN  resolved source operands
- `out_rs1`, `out_rs2`, `out_rd`  out  5  carried addresses
- `out_rd_we`, `out_is_load`  out  1  carried flags

## Operation
- Operand resolution, per source `rsN`:
  - `rsN == 0` gives 0, never bypassed.
  - Otherwise, if `RegWE_E && A3 == rsN`, use `WD3`.
  - Otherwise, if `RegWE_W && A4 == rsN`, use `WD4`.
  - Otherwise use `RD`.
  - Execute wins over Writeback when both write the same register.
- Scoreboard `busy[31:1]`:
  - Set bit `out_rd` when the slot issues (`out_valid && out_ready && !flush`) with `out_rd_we && out_is_load && out_rd != 0`.
  - Clear bit `A4` when `RegWE_W`.
  - If set and clear hit the same bit in one cycle, set wins.
  - `busy[0]` is constant 0.
- Hazard, for `rsN != 0` (only sources the instruction reads; rs of 0 never hazards):
  - `busy[rsN]` is set and this cycle's `RegWE_W && A4 == rsN` is not true, OR
  - `out_valid && out_rd_we && out_is_load && out_rd == rsN`.
- `in_ready = !reset && !hazard && (!out_valid || out_ready || flush)`.
- Accept (`in_valid && in_ready`): load the slot with resolved operands and carried fields; `out_valid` is set.
- Slot consumed without accept: `out_valid` is cleared.
- Hold (`out_valid && !out_ready && !flush`): the slot keeps snooping. A write to `out_rs1`/`out_rs2` (nonzero) updates `out_op1`/`out_op2` using the same E-over-W priority, because an older in-flight write must still land in held operands.
- `flush`:
  - Clears `out_valid` next edge; suppresses the scoreboard set.
  - Does not alter `busy`.
  - An accept in the same cycle is still taken, so the new instruction fills the slot.

## Timing
- Reset (synchronous): `out_valid=0`, `out_op1=out_op2=0`, all `out_*` fields 0, `busy=0`. `in_ready=0` while `reset` is high.
- Latency: 1 cycle from accept edge to `out_valid`. Throughput: 1/cycle when `out_ready` is held high.
- `A1`/`A2` and `in_ready` are combinational from inputs and state. All `out_*` are registered.
- Bypass covers a GPR write on the same edge the instruction is accepted. The GPR covers writes on earlier edges.
- Load-use: dependent instruction stalls until the cycle `RegWE_W` writes that rd. It is accepted that cycle, with `WD4` bypassed.
- Reset asserted mid-stall or mid-hold discards the slot and scoreboard; there is no partial state.

## Test plan
- Reset, then accept `rs1=1, rs2=0` with `RD1=0x11111111` and no writes -> next cycle `out_valid=1`, `out_op1=0x11111111`, `out_op2=0`.
- Accept `rs1=2` while `RegWE_E=1,A3=2,WD3=0xAAAAAAAA` and `RegWE_W=1,A4=2,WD4=0xBBBBBBBB`, `RD1=0` -> `out_op1=0xAAAAAAAA`.
- Accept `rs1=0` while `RegWE_E=1,A3=0,WD3=0xFFFFFFFF` -> `out_op1=0`.
- Issue load `rd=5`, then present `rs2=5`:
  - `in_ready=0` for 3 cycles.
  - 4th cycle `RegWE_W=1,A4=5,WD4=0xA00AA00A` -> accepted, `out_op2=0xA00AA00A`, `busy[5]=0`.
- Hold slot with `rs1=3`, `out_ready=0`; pulse `RegWE_W=1,A4=3,WD4=0x12345678` -> `out_op1=0x12345678` after the edge, `out_valid` still 1.
- Slot holds load `rd=7`, then `flush=1` with `out_ready=1` -> `out_valid=0`, `busy[7]=0`; a following instruction reading `rs1=7` is accepted immediately.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch
//   Decode-side GPR reader. Accepts decoded instructions on a valid/ready
//   handshake, drives the GPR read addresses, merges the read data with
//   same-cycle bypass from the Execute and Writeback write ports, and holds the
//   result in a registered ID/EX operand slot. A load scoreboard stalls
//   instructions whose sources still wait on an outstanding load.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   in_valid / in_ready         decoded-instruction handshake (in_ready is comb)
//   in_rs1, in_rs2, in_rd       source / destination register addresses
//   in_rd_we, in_is_load        destination write enable, load flag
//   A1, A2                      GPR read addresses (comb, = in_rs1 / in_rs2)
//   RD1, RD2                    GPR read data (pre-write value)
//   RegWE_E, A3, WD3            snooped Execute write port
//   RegWE_W, A4, WD4            snooped Writeback write port
//   flush                       kill the held slot
//   out_valid / out_ready       operand slot handshake towards Execute
//   out_op1, out_op2            resolved source operands (registered)
//   out_rs1, out_rs2, out_rd    carried addresses (registered)
//   out_rd_we, out_is_load      carried flags (registered)
module operand_fetch #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_we,
  input  logic            in_is_load,
  output logic [AW-1:0]   A1,
  output logic [AW-1:0]   A2,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic            RegWE_E,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            RegWE_W,
  input  logic [AW-1:0]   A4,
  input  logic [XLEN-1:0] WD4,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [AW-1:0]   out_rs1,
  output logic [AW-1:0]   out_rs2,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_we,
  output logic            out_is_load
);

  // Operand slot registers
  logic            vld_p0;
  logic [XLEN-1:0] op1_p0, op2_p0;
  logic [AW-1:0]   rs1_p0, rs2_p0, rd_p0;
  logic            rd_we_p0, is_load_p0;

  // Load scoreboard; bit 0 is never set
  logic [NREG-1:0] busy, busy_nxt;

  logic [XLEN-1:0] res1, res2, hold1, hold2;
  logic            hz1, hz2, hazard;
  logic            accept, issue, hold, set_busy;

  // Register x0 reads as zero and is never bypassed; Execute is younger than
  // Writeback, so it wins when both target the same register.
  function automatic logic [XLEN-1:0] resolve(
    input logic [AW-1:0]   rs,
    input logic [XLEN-1:0] dflt,
    input logic            we_e,
    input logic [AW-1:0]   a_e,
    input logic [XLEN-1:0] wd_e,
    input logic            we_w,
    input logic [AW-1:0]   a_w,
    input logic [XLEN-1:0] wd_w
  );
    if (rs == '0)                 return '0;
    else if (we_e && a_e == rs)   return wd_e;
    else if (we_w && a_w == rs)   return wd_w;
    else                          return dflt;
  endfunction

  // A source stalls if a load to it is already issued (and Writeback is not
  // delivering it right now), or if the slot itself holds such a load.
  function automatic logic src_hazard(
    input logic [AW-1:0]   rs,
    input logic [NREG-1:0] bsy,
    input logic            we_w,
    input logic [AW-1:0]   a_w,
    input logic            slot_load_vld,
    input logic [AW-1:0]   slot_rd
  );
    if (rs == '0) return 1'b0;
    return (bsy[rs] && !(we_w && a_w == rs)) || (slot_load_vld && slot_rd == rs);
  endfunction

  assign A1 = in_rs1;
  assign A2 = in_rs2;

  always_comb begin
    res1  = resolve(in_rs1, RD1,    RegWE_E, A3, WD3, RegWE_W, A4, WD4);
    res2  = resolve(in_rs2, RD2,    RegWE_E, A3, WD3, RegWE_W, A4, WD4);
    // While held, an older in-flight write must still land in the operands
    hold1 = resolve(rs1_p0, op1_p0, RegWE_E, A3, WD3, RegWE_W, A4, WD4);
    hold2 = resolve(rs2_p0, op2_p0, RegWE_E, A3, WD3, RegWE_W, A4, WD4);

    hz1    = src_hazard(in_rs1, busy, RegWE_W, A4,
                        vld_p0 && rd_we_p0 && is_load_p0, rd_p0);
    hz2    = src_hazard(in_rs2, busy, RegWE_W, A4,
                        vld_p0 && rd_we_p0 && is_load_p0, rd_p0);
    hazard = hz1 || hz2;

    in_ready = !reset && !hazard && (!vld_p0 || out_ready || flush);
    accept   = in_valid && in_ready;
    issue    = vld_p0 && out_ready && !flush;
    hold     = vld_p0 && !out_ready && !flush;
    set_busy = issue && rd_we_p0 && is_load_p0 && (rd_p0 != '0);
  end

  // Set is applied after clear so a same-cycle set on the same bit wins
  always_comb begin
    busy_nxt = busy;
    if (RegWE_W)  busy_nxt[A4]    = 1'b0;
    if (set_busy) busy_nxt[rd_p0] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Stage p0: ID/EX operand slot and scoreboard
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      op1_p0     <= '0;
      op2_p0     <= '0;
      rs1_p0     <= '0;
      rs2_p0     <= '0;
      rd_p0      <= '0;
      rd_we_p0   <= 1'b0;
      is_load_p0 <= 1'b0;
      busy       <= '0;
    end else begin
      busy <= busy_nxt;
      if (accept) begin
        vld_p0     <= 1'b1;
        op1_p0     <= res1;
        op2_p0     <= res2;
        rs1_p0     <= in_rs1;
        rs2_p0     <= in_rs2;
        rd_p0      <= in_rd;
        rd_we_p0   <= in_rd_we;
        is_load_p0 <= in_is_load;
      end else if (hold) begin
        op1_p0 <= hold1;
        op2_p0 <= hold2;
      end else begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign out_valid   = vld_p0;
  assign out_op1     = op1_p0;
  assign out_op2     = op2_p0;
  assign out_rs1     = rs1_p0;
  assign out_rs2     = rs2_p0;
  assign out_rd      = rd_p0;
  assign out_rd_we   = rd_we_p0;
  assign out_is_load = is_load_p0;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we, in_is_load;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2;
  logic        RegWE_E;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        RegWE_W;
  logic [4:0]  A4;
  logic [31:0] WD4;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rd_we, out_is_load;

  int checks = 0;
  int errors = 0;

  operand_fetch #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd_we(in_rd_we), .in_is_load(in_is_load),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .RegWE_E(RegWE_E), .A3(A3), .WD3(WD3),
    .RegWE_W(RegWE_W), .A4(A4), .WD4(WD4),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_is_load(out_is_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we;
    logic [31:0] rd1, rd2;
    logic        we_e;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we_w;
    logic [4:0]  a4;
    logic [31:0] wd4;
    logic [31:0] exp1, exp2;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0; in_is_load = 0;
    RD1 = 0; RD2 = 0; RegWE_E = 0; A3 = 0; WD3 = 0; RegWE_W = 0; A4 = 0; WD4 = 0;
    flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction (inputs change #1 after an edge)
  task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rd_we, input logic is_load,
                         input logic [31:0] rd1, input logic [31:0] rd2);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rd_we = rd_we; in_is_load = is_load; RD1 = rd1; RD2 = rd2;
  endtask

  initial begin
    vecs[0] = '{5'd1,  5'd0,  5'd11, 1'b1, 32'h11111111, 32'h22222222,
                1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                32'h11111111, 32'h00000000};
    vecs[1] = '{5'd2,  5'd3,  5'd12, 1'b0, 32'h00000000, 32'h33333333,
                1'b1, 5'd2, 32'hAAAAAAAA, 1'b1, 5'd2, 32'hBBBBBBBB,
                32'hAAAAAAAA, 32'h33333333};
    vecs[2] = '{5'd0,  5'd4,  5'd13, 1'b1, 32'h12121212, 32'h44444444,
                1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,
                32'h00000000, 32'h44444444};
    vecs[3] = '{5'd6,  5'd6,  5'd14, 1'b0, 32'h00000001, 32'h00000002,
                1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 32'hCAFEBABE,
                32'hCAFEBABE, 32'hCAFEBABE};
    vecs[4] = '{5'd8,  5'd9,  5'd15, 1'b1, 32'h00000008, 32'h00000009,
                1'b1, 5'd9, 32'h00009999, 1'b1, 5'd8, 32'h00008888,
                32'h00008888, 32'h00009999};
    vecs[5] = '{5'd31, 5'd31, 5'd31, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF,
                1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                32'hDEADBEEF, 32'hDEADBEEF};
    vecs[6] = '{5'd10, 5'd0,  5'd16, 1'b0, 32'h0A0A0A0A, 32'h77777777,
                1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h00005555,
                32'h0A0A0A0A, 32'h00000000};

    idle();
    out_ready = 0;
    reset = 1;
    in_valid = 1; in_rs1 = 5'd1;
    tick(); tick();
    check("reset in_ready", {31'b0, in_ready}, 32'h0);
    check("reset out_valid", {31'b0, out_valid}, 32'h0);
    check("reset out_op1", out_op1, 32'h0);
    check("reset out_rd", {27'b0, out_rd}, 32'h0);
    check("A1 passthrough", {27'b0, A1}, 32'd1);
    reset = 0;
    idle();
    out_ready = 1;

    // Table: back-to-back accepts with bypass patterns
    for (int i = 0; i < 7; i++) begin
      present(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rd_we, 1'b0,
              vecs[i].rd1, vecs[i].rd2);
      RegWE_E = vecs[i].we_e; A3 = vecs[i].a3; WD3 = vecs[i].wd3;
      RegWE_W = vecs[i].we_w; A4 = vecs[i].a4; WD4 = vecs[i].wd4;
      #1;
      check($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, 32'h1);
      tick();
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'h1);
      check($sformatf("vec%0d out_op1", i), out_op1, vecs[i].exp1);
      check($sformatf("vec%0d out_op2", i), out_op2, vecs[i].exp2);
      check($sformatf("vec%0d out_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
      check($sformatf("vec%0d out_rd_we", i), {31'b0, out_rd_we}, {31'b0, vecs[i].rd_we});
    end
    idle();
    tick();
    check("drain out_valid", {31'b0, out_valid}, 32'h0);

    // Load-use: load rd=5, dependent rs2=5 stalls 3 cycles
    present(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 32'h0, 32'h0);
    tick();
    check("load out_is_load", {31'b0, out_is_load}, 32'h1);
    present(5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0, 32'h5);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("loaduse stall%0d in_ready", c), {31'b0, in_ready}, 32'h0);
      tick();
    end
    RegWE_W = 1; A4 = 5'd5; WD4 = 32'hA00AA00A;
    #1;
    check("loaduse wb in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    check("loaduse out_valid", {31'b0, out_valid}, 32'h1);
    check("loaduse out_op2", out_op2, 32'hA00AA00A);
    idle();
    present(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 32'h55, 32'h0);
    #1;
    check("busy5 cleared in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    check("busy5 cleared op1", out_op1, 32'h55);

    // Hold: slot rs1=3 held, WB write lands in held operand
    present(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 32'h00000003, 32'h0);
    tick();
    idle();
    out_ready = 0;
    in_valid = 1;
    RegWE_W = 1; A4 = 5'd3; WD4 = 32'h12345678;
    #1;
    check("hold in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    check("hold out_op1", out_op1, 32'h12345678);
    check("hold out_valid", {31'b0, out_valid}, 32'h1);
    RegWE_E = 1; A3 = 5'd3; WD3 = 32'h0E0E0E0E;
    WD4 = 32'h0B0B0B0B;
    tick();
    check("hold E over W", out_op1, 32'h0E0E0E0E);
    idle();
    tick();
    check("hold no write keeps", out_op1, 32'h0E0E0E0E);
    out_ready = 1;
    tick();
    check("hold released", {31'b0, out_valid}, 32'h0);

    // Flush of a held load: no scoreboard set
    present(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0);
    tick();
    idle();
    flush = 1;
    tick();
    flush = 0;
    check("flush out_valid", {31'b0, out_valid}, 32'h0);
    present(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 32'h77, 32'h0);
    #1;
    check("after flush rs7 in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    check("after flush out_valid", {31'b0, out_valid}, 32'h1);

    // Flush with simultaneous accept while held
    out_ready = 0;
    flush = 1;
    present(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h00000077, 32'h0);
    #1;
    check("flush+accept in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    flush = 0;
    idle();
    check("flush+accept out_valid", {31'b0, out_valid}, 32'h1);
    check("flush+accept out_op1", out_op1, 32'h00000077);

    // Reset mid-hold with a busy scoreboard bit
    out_ready = 1;
    tick();
    present(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    present(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 32'h99, 32'h0);
    #1;
    check("busy9 stall in_ready", {31'b0, in_ready}, 32'h0);
    present(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h00005A5A, 32'h0);
    out_ready = 0;
    tick();
    check("pre-reset held op1", out_op1, 32'h00005A5A);
    reset = 1;
    #1;
    check("mid-hold reset in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    reset = 0;
    check("mid-hold reset out_valid", {31'b0, out_valid}, 32'h0);
    check("mid-hold reset out_op1", out_op1, 32'h0);
    check("mid-hold reset out_rs1", {27'b0, out_rs1}, 32'h0);
    out_ready = 1;
    present(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 32'h99, 32'h0);
    #1;
    check("busy9 reset in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    check("busy9 reset out_op1", out_op1, 32'h99);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
